// File: rtl/ncpu32k_idu_queue.sv
// Instruction queue between fetch and issue: circular buffer of {insn, exc} with a
// combinational head decoder that picks how many in-order slots may issue together.
`timescale 1ns/1ps

`ifndef NCPU_IW
`define NCPU_IW 32
`endif
`ifndef NCPU_REG_AW
`define NCPU_REG_AW 5
`endif
`ifndef NCPU_REGNO_LNK
`define NCPU_REGNO_LNK 1
`endif
`ifndef NCPU_OP_ADD
`define NCPU_OP_ADD       7'h01
`define NCPU_OP_ADD_I     7'h02
`define NCPU_OP_AND       7'h03
`define NCPU_OP_AND_I     7'h04
`define NCPU_OP_OR        7'h05
`define NCPU_OP_OR_I      7'h06
`define NCPU_OP_XOR       7'h07
`define NCPU_OP_XOR_I     7'h08
`define NCPU_OP_SUB       7'h09
`define NCPU_OP_LDW       7'h0a
`define NCPU_OP_LDH       7'h0b
`define NCPU_OP_LDB       7'h0c
`define NCPU_OP_STW       7'h0d
`define NCPU_OP_STH       7'h0e
`define NCPU_OP_STB       7'h0f
`define NCPU_OP_BEQ       7'h10
`define NCPU_OP_BNE       7'h11
`define NCPU_OP_BGT       7'h12
`define NCPU_OP_BGTU      7'h13
`define NCPU_OP_BLE       7'h14
`define NCPU_OP_BLEU      7'h15
`define NCPU_OP_JMP_I     7'h16
`define NCPU_OP_JMP_LNK_I 7'h17
`define NCPU_OP_JMP       7'h18
`define NCPU_OP_MHI       7'h19
`define NCPU_OP_MBARR     7'h1a
`define NCPU_OP_SYSCALL   7'h1b
`define NCPU_OP_RET       7'h1c
`define NCPU_OP_WMSR      7'h1d
`define NCPU_OP_RMSR      7'h1e
`endif

module ncpu32k_idu_queue #(
   parameter int unsigned CONFIG_FW         = 2,
   parameter int unsigned CONFIG_IW         = 2,
   parameter int unsigned CONFIG_DEPTH_LOG2 = 3
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     flush,
   input  logic                                     fe_valid,
   output logic                                     fe_ready,
   input  logic [$clog2(CONFIG_FW):0]               fe_cnt,
   input  logic [CONFIG_FW*`NCPU_IW-1:0]            fe_insn,
   input  logic [CONFIG_FW*3-1:0]                   fe_exc,
   output logic [$clog2(CONFIG_IW):0]               iss_cnt,
   input  logic                                     iss_ready,
   output logic [CONFIG_IW*`NCPU_IW-1:0]            iss_insn,
   output logic [CONFIG_IW*3-1:0]                   iss_exc,
   output logic [CONFIG_IW-1:0]                     iss_rs1_re,
   output logic [CONFIG_IW*`NCPU_REG_AW-1:0]        iss_rs1_addr,
   output logic [CONFIG_IW-1:0]                     iss_rs2_re,
   output logic [CONFIG_IW*`NCPU_REG_AW-1:0]        iss_rs2_addr,
   output logic [CONFIG_IW-1:0]                     iss_wb_regf,
   output logic [CONFIG_IW*`NCPU_REG_AW-1:0]        iss_wb_reg_addr,
   output logic [CONFIG_IW-1:0]                     iss_serial
);

   localparam int unsigned D   = 1 << CONFIG_DEPTH_LOG2;
   localparam int unsigned PW  = CONFIG_DEPTH_LOG2;
   localparam int unsigned CW  = CONFIG_DEPTH_LOG2 + 1;
   localparam int unsigned ICW = $clog2(CONFIG_IW) + 1;
   localparam int unsigned IWD = `NCPU_IW;
   localparam int unsigned AW  = `NCPU_REG_AW;

   typedef struct packed {
      logic [IWD-1:0] insn;
      logic [2:0]     exc;
   } ent_t;

   typedef struct packed {
      logic          rs1_re;
      logic [AW-1:0] rs1_addr;
      logic          rs2_re;
      logic [AW-1:0] rs2_addr;
      logic          wb_regf;
      logic [AW-1:0] wb_addr;
      logic          serial;
   } dec_t;

   ent_t          mem_q [D];
   logic [PW-1:0] rptr_q, rptr_d;
   logic [PW-1:0] wptr_q, wptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          enq, deq;
   ent_t          head [CONFIG_IW];
   dec_t          dec  [CONFIG_IW];
   logic          issue_ok, hazard;

   function automatic dec_t decode(input ent_t e);
      dec_t          d;
      logic [6:0]    op;
      logic [AW-1:0] rd;
      logic          no_rs1, no_rs2, rs2_is_rd, no_wb, ser;
      op        = e.insn[6:0];
      rd        = e.insn[7 +: AW];
      no_rs1    = 1'b0;
      no_rs2    = 1'b0;
      rs2_is_rd = 1'b0;
      no_wb     = 1'b0;
      ser       = 1'b0;
      case (op)
         `NCPU_OP_ADD, `NCPU_OP_AND, `NCPU_OP_OR, `NCPU_OP_XOR, `NCPU_OP_SUB,
         `NCPU_OP_JMP: begin
         end
         `NCPU_OP_ADD_I, `NCPU_OP_AND_I, `NCPU_OP_OR_I, `NCPU_OP_XOR_I,
         `NCPU_OP_LDW, `NCPU_OP_LDH, `NCPU_OP_LDB: no_rs2 = 1'b1;
         `NCPU_OP_STW, `NCPU_OP_STH, `NCPU_OP_STB,
         `NCPU_OP_BEQ, `NCPU_OP_BNE, `NCPU_OP_BGT, `NCPU_OP_BGTU,
         `NCPU_OP_BLE, `NCPU_OP_BLEU: begin
            rs2_is_rd = 1'b1;
            no_wb     = 1'b1;
         end
         `NCPU_OP_WMSR: begin
            rs2_is_rd = 1'b1;
            no_wb     = 1'b1;
            ser       = 1'b1;
         end
         `NCPU_OP_RMSR: begin
            no_rs2 = 1'b1;
            ser    = 1'b1;
         end
         `NCPU_OP_MHI, `NCPU_OP_JMP_LNK_I: begin
            no_rs1 = 1'b1;
            no_rs2 = 1'b1;
         end
         `NCPU_OP_JMP_I: begin
            no_rs1 = 1'b1;
            no_rs2 = 1'b1;
            no_wb  = 1'b1;
         end
         `NCPU_OP_MBARR, `NCPU_OP_SYSCALL, `NCPU_OP_RET: begin
            no_rs1 = 1'b1;
            no_rs2 = 1'b1;
            no_wb  = 1'b1;
            ser    = 1'b1;
         end
         default: begin
            no_wb = 1'b1;
            ser   = 1'b1;
         end
      endcase
      d.rs1_re   = ~no_rs1;
      d.rs1_addr = e.insn[12 +: AW];
      d.rs2_re   = ~no_rs2;
      d.rs2_addr = rs2_is_rd ? rd : e.insn[17 +: AW];
      d.wb_addr  = (op == `NCPU_OP_JMP_LNK_I) ? AW'(`NCPU_REGNO_LNK) : rd;
      d.wb_regf  = ~no_wb & (d.wb_addr != '0);
      d.serial   = ser;
      // Frontend exceptions behave as a serialising no-op.
      if (e.exc != 3'b000) begin
         d.rs1_re  = 1'b0;
         d.rs2_re  = 1'b0;
         d.wb_regf = 1'b0;
         d.serial  = 1'b1;
      end
      return d;
   endfunction

   assign fe_ready = (count_q <= CW'(D - CONFIG_FW));
   assign enq      = fe_valid & fe_ready;
   assign deq      = iss_ready & (iss_cnt != '0);

   always_ff @(posedge clk) begin
      if (enq) begin
         for (int k = 0; k < int'(CONFIG_FW); k++) begin
            if (k < int'(fe_cnt)) begin
               mem_q[wptr_q + PW'(k)] <= '{insn: fe_insn[k*IWD +: IWD], exc: fe_exc[k*3 +: 3]};
            end
         end
      end
   end

   always_comb begin
      rptr_d  = rptr_q;
      wptr_d  = wptr_q;
      count_d = count_q;
      if (flush) begin
         rptr_d  = '0;
         wptr_d  = '0;
         count_d = '0;
      end else begin
         if (enq) wptr_d = wptr_q + PW'(fe_cnt);
         if (deq) rptr_d = rptr_q + PW'(iss_cnt);
         count_d = count_q + (enq ? CW'(fe_cnt) : '0) - (deq ? CW'(iss_cnt) : '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
      end else begin
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      for (int k = 0; k < int'(CONFIG_IW); k++) begin
         head[k] = mem_q[rptr_q + PW'(k)];
         dec[k]  = decode(head[k]);
      end
   end

   // Grow the issue group slot by slot; stop at the first slot that cannot join.
   always_comb begin
      iss_cnt  = '0;
      issue_ok = 1'b1;
      hazard   = 1'b0;
      for (int k = 0; k < int'(CONFIG_IW); k++) begin
         hazard = 1'b0;
         for (int j = 0; j < k; j++) begin
            if (dec[j].wb_regf &&
                ((dec[k].rs1_re && dec[k].rs1_addr == dec[j].wb_addr) ||
                 (dec[k].rs2_re && dec[k].rs2_addr == dec[j].wb_addr))) begin
               hazard = 1'b1;
            end
         end
         if (issue_ok && (CW'(k) < count_q) &&
             (k == 0 || (!dec[k].serial && !dec[0].serial && !hazard))) begin
            iss_cnt = ICW'(k + 1);
         end else begin
            issue_ok = 1'b0;
         end
      end
   end

   always_comb begin
      iss_insn        = '0;
      iss_exc         = '0;
      iss_rs1_re      = '0;
      iss_rs1_addr    = '0;
      iss_rs2_re      = '0;
      iss_rs2_addr    = '0;
      iss_wb_regf     = '0;
      iss_wb_reg_addr = '0;
      iss_serial      = '0;
      for (int k = 0; k < int'(CONFIG_IW); k++) begin
         iss_insn[k*IWD +: IWD]       = head[k].insn;
         iss_exc[k*3 +: 3]            = head[k].exc;
         iss_rs1_re[k]                = dec[k].rs1_re;
         iss_rs1_addr[k*AW +: AW]     = dec[k].rs1_addr;
         iss_rs2_re[k]                = dec[k].rs2_re;
         iss_rs2_addr[k*AW +: AW]     = dec[k].rs2_addr;
         iss_wb_regf[k]               = dec[k].wb_regf;
         iss_wb_reg_addr[k*AW +: AW]  = dec[k].wb_addr;
         iss_serial[k]                = dec[k].serial;
      end
   end

endmodule

// File: tb/tb_ncpu32k_idu_queue.sv
// Self-checking bench for ncpu32k_idu_queue: directed scenarios plus random traffic,
// all checked against a queue-based reference model.
`timescale 1ns/1ps

`ifndef NCPU_IW
`define NCPU_IW 32
`endif
`ifndef NCPU_REG_AW
`define NCPU_REG_AW 5
`endif
`ifndef NCPU_REGNO_LNK
`define NCPU_REGNO_LNK 1
`endif
`ifndef NCPU_OP_ADD
`define NCPU_OP_ADD       7'h01
`define NCPU_OP_ADD_I     7'h02
`define NCPU_OP_AND       7'h03
`define NCPU_OP_AND_I     7'h04
`define NCPU_OP_OR        7'h05
`define NCPU_OP_OR_I      7'h06
`define NCPU_OP_XOR       7'h07
`define NCPU_OP_XOR_I     7'h08
`define NCPU_OP_SUB       7'h09
`define NCPU_OP_LDW       7'h0a
`define NCPU_OP_LDH       7'h0b
`define NCPU_OP_LDB       7'h0c
`define NCPU_OP_STW       7'h0d
`define NCPU_OP_STH       7'h0e
`define NCPU_OP_STB       7'h0f
`define NCPU_OP_BEQ       7'h10
`define NCPU_OP_BNE       7'h11
`define NCPU_OP_BGT       7'h12
`define NCPU_OP_BGTU      7'h13
`define NCPU_OP_BLE       7'h14
`define NCPU_OP_BLEU      7'h15
`define NCPU_OP_JMP_I     7'h16
`define NCPU_OP_JMP_LNK_I 7'h17
`define NCPU_OP_JMP       7'h18
`define NCPU_OP_MHI       7'h19
`define NCPU_OP_MBARR     7'h1a
`define NCPU_OP_SYSCALL   7'h1b
`define NCPU_OP_RET       7'h1c
`define NCPU_OP_WMSR      7'h1d
`define NCPU_OP_RMSR      7'h1e
`endif

module tb_ncpu32k_idu_queue;

   localparam int FW = 2;
   localparam int IW = 2;
   localparam int D  = 8;

   localparam logic [6:0] OPS [30] = '{
      `NCPU_OP_ADD, `NCPU_OP_ADD_I, `NCPU_OP_AND, `NCPU_OP_AND_I, `NCPU_OP_OR,
      `NCPU_OP_OR_I, `NCPU_OP_XOR, `NCPU_OP_XOR_I, `NCPU_OP_SUB, `NCPU_OP_LDW,
      `NCPU_OP_LDH, `NCPU_OP_LDB, `NCPU_OP_STW, `NCPU_OP_STH, `NCPU_OP_STB,
      `NCPU_OP_BEQ, `NCPU_OP_BNE, `NCPU_OP_BGT, `NCPU_OP_BGTU, `NCPU_OP_BLE,
      `NCPU_OP_BLEU, `NCPU_OP_JMP_I, `NCPU_OP_JMP_LNK_I, `NCPU_OP_JMP, `NCPU_OP_MHI,
      `NCPU_OP_MBARR, `NCPU_OP_SYSCALL, `NCPU_OP_RET, `NCPU_OP_WMSR, `NCPU_OP_RMSR};

   logic          clk = 1'b0;
   logic          rst, flush, fe_valid, fe_ready, iss_ready;
   logic [1:0]    fe_cnt, iss_cnt;
   logic [63:0]   fe_insn, iss_insn;
   logic [5:0]    fe_exc, iss_exc;
   logic [1:0]    iss_rs1_re, iss_rs2_re, iss_wb_regf, iss_serial;
   logic [9:0]    iss_rs1_addr, iss_rs2_addr, iss_wb_reg_addr;

   typedef struct {
      logic [31:0] insn;
      logic [2:0]  exc;
   } ent_t;

   typedef struct {
      bit         r1e;
      logic [4:0] r1a;
      bit         r2e;
      logic [4:0] r2a;
      bit         wbf;
      logic [4:0] wba;
      bit         ser;
   } ref_t;

   ent_t q[$];
   int   n_total = 0;
   int   n_bad   = 0;

   always #5 clk = ~clk;

   ncpu32k_idu_queue #(
      .CONFIG_FW        (FW),
      .CONFIG_IW        (IW),
      .CONFIG_DEPTH_LOG2(3)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .fe_valid       (fe_valid),
      .fe_ready       (fe_ready),
      .fe_cnt         (fe_cnt),
      .fe_insn        (fe_insn),
      .fe_exc         (fe_exc),
      .iss_cnt        (iss_cnt),
      .iss_ready      (iss_ready),
      .iss_insn       (iss_insn),
      .iss_exc        (iss_exc),
      .iss_rs1_re     (iss_rs1_re),
      .iss_rs1_addr   (iss_rs1_addr),
      .iss_rs2_re     (iss_rs2_re),
      .iss_rs2_addr   (iss_rs2_addr),
      .iss_wb_regf    (iss_wb_regf),
      .iss_wb_reg_addr(iss_wb_reg_addr),
      .iss_serial     (iss_serial)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mk(input logic [6:0] op, input int rd, input int rs1,
                                      input int rs2);
      return {10'd0, 5'(rs2), 5'(rs1), 5'(rd), op};
   endfunction

   // Field rules written straight from the opcode classes.
   function automatic ref_t ref_dec(input ent_t e);
      ref_t       r;
      logic [6:0] op;
      bit         known, ok, rs2_rd;
      op     = e.insn[6:0];
      ok     = (e.exc == 3'b000);
      known  = op inside {OPS};
      rs2_rd = op inside {`NCPU_OP_STB, `NCPU_OP_STH, `NCPU_OP_STW, `NCPU_OP_WMSR,
                          `NCPU_OP_BEQ, `NCPU_OP_BNE, `NCPU_OP_BGT, `NCPU_OP_BGTU,
                          `NCPU_OP_BLE, `NCPU_OP_BLEU};
      r.r1e = ok && !(op inside {`NCPU_OP_MHI, `NCPU_OP_MBARR, `NCPU_OP_SYSCALL,
                                 `NCPU_OP_RET, `NCPU_OP_JMP_I, `NCPU_OP_JMP_LNK_I});
      r.r1a = e.insn[16:12];
      r.r2e = ok && (rs2_rd || !(op inside {`NCPU_OP_ADD_I, `NCPU_OP_AND_I, `NCPU_OP_OR_I,
                     `NCPU_OP_XOR_I, `NCPU_OP_LDB, `NCPU_OP_LDH, `NCPU_OP_LDW,
                     `NCPU_OP_RMSR, `NCPU_OP_MHI, `NCPU_OP_JMP_I, `NCPU_OP_JMP_LNK_I,
                     `NCPU_OP_MBARR, `NCPU_OP_SYSCALL, `NCPU_OP_RET}));
      r.r2a = rs2_rd ? e.insn[11:7] : e.insn[21:17];
      r.wba = (op == `NCPU_OP_JMP_LNK_I) ? 5'(`NCPU_REGNO_LNK) : e.insn[11:7];
      r.wbf = ok && known && (r.wba != 0) && !rs2_rd &&
              !(op inside {`NCPU_OP_JMP_I, `NCPU_OP_MBARR, `NCPU_OP_SYSCALL, `NCPU_OP_RET});
      r.ser = !ok || !known || (op inside {`NCPU_OP_SYSCALL, `NCPU_OP_RET, `NCPU_OP_WMSR,
                                           `NCPU_OP_RMSR, `NCPU_OP_MBARR});
      return r;
   endfunction

   function automatic bit group_ok(input int n);
      ref_t r [IW];
      for (int k = 0; k < n; k++) r[k] = ref_dec(q[k]);
      for (int k = 1; k < n; k++) begin
         if (r[k].ser || r[0].ser) return 0;
         for (int j = 0; j < k; j++)
            if (r[j].wbf && ((r[k].r1e && r[k].r1a == r[j].wba) ||
                             (r[k].r2e && r[k].r2a == r[j].wba))) return 0;
      end
      return 1;
   endfunction

   function automatic int exp_iss();
      int lim = (q.size() < IW) ? q.size() : IW;
      for (int n = lim; n >= 1; n--) if (group_ok(n)) return n;
      return 0;
   endfunction

   task automatic check_model();
      int   n;
      ref_t r;
      n = exp_iss();
      check_eq("fe_ready", 32'(fe_ready), 32'(D - q.size() >= FW));
      check_eq("iss_cnt", 32'(iss_cnt), 32'(n));
      for (int k = 0; k < n; k++) begin
         r = ref_dec(q[k]);
         check_eq("insn", iss_insn[k*32 +: 32], q[k].insn);
         check_eq("exc", 32'(iss_exc[k*3 +: 3]), 32'(q[k].exc));
         check_eq("rs1_re", 32'(iss_rs1_re[k]), 32'(r.r1e));
         if (r.r1e) check_eq("rs1_addr", 32'(iss_rs1_addr[k*5 +: 5]), 32'(r.r1a));
         check_eq("rs2_re", 32'(iss_rs2_re[k]), 32'(r.r2e));
         if (r.r2e) check_eq("rs2_addr", 32'(iss_rs2_addr[k*5 +: 5]), 32'(r.r2a));
         check_eq("wb_regf", 32'(iss_wb_regf[k]), 32'(r.wbf));
         if (r.wbf) check_eq("wb_addr", 32'(iss_wb_reg_addr[k*5 +: 5]), 32'(r.wba));
         check_eq("serial", 32'(iss_serial[k]), 32'(r.ser));
      end
   endtask

   // Check current outputs, apply one cycle of inputs, advance the model past the edge.
   task automatic step(input bit v, input int c, input logic [31:0] i0, input logic [31:0] i1,
                       input logic [2:0] e0, input logic [2:0] e1, input bit rdy,
                       input bit fl, input bit rs);
      int n;
      bit acc;
      check_model();
      fe_valid  = v;
      fe_cnt    = 2'(c);
      fe_insn   = {i1, i0};
      fe_exc    = {e1, e0};
      iss_ready = rdy;
      flush     = fl;
      rst       = rs;
      n   = exp_iss();
      acc = v && (D - q.size() >= FW);
      if (rs || fl) begin
         q.delete();
      end else begin
         if (rdy) repeat (n) void'(q.pop_front());
         if (acc) begin
            q.push_back('{insn: i0, exc: e0});
            if (c == 2) q.push_back('{insn: i1, exc: e1});
         end
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_insn();
      int         sel;
      logic [6:0] op;
      sel = $urandom_range(0, 32);
      if (sel >= 30) op = (sel == 30) ? 7'h00 : 7'h7f;
      else op = OPS[sel];
      return {10'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), op};
   endfunction

   initial begin
      logic [31:0] a0, a1;
      rst = 1'b1; flush = 1'b0; fe_valid = 1'b0; fe_cnt = 2'd1;
      fe_insn = '0; fe_exc = '0; iss_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check_eq("rst_fe_ready", 32'(fe_ready), 32'd1);
      check_eq("rst_iss_cnt", 32'(iss_cnt), 32'd0);

      // Two independent ADDs issue together.
      step(1, 2, mk(`NCPU_OP_ADD, 1, 4, 5), mk(`NCPU_OP_ADD, 2, 6, 7), 0, 0, 0, 0, 0);
      check_eq("pair_cnt", 32'(iss_cnt), 32'd2);
      check_eq("pair_wb", 32'(iss_wb_regf), 32'd3);
      step(0, 1, 0, 0, 0, 0, 1, 0, 0);
      check_eq("pair_drain", 32'(iss_cnt), 32'd0);

      // RAW between slots splits the group.
      step(1, 2, mk(`NCPU_OP_ADD, 3, 0, 0), mk(`NCPU_OP_ADD, 4, 3, 0), 0, 0, 0, 0, 0);
      check_eq("raw_cnt", 32'(iss_cnt), 32'd1);
      step(0, 1, 0, 0, 0, 0, 1, 0, 0);
      check_eq("raw_cnt2", 32'(iss_cnt), 32'd1);
      check_eq("raw_insn2", iss_insn[31:0], mk(`NCPU_OP_ADD, 4, 3, 0));
      step(0, 1, 0, 0, 0, 0, 1, 0, 0);

      // Fill to capacity, then confirm wrap by issue order.
      for (int b = 0; b < 4; b++)
         step(1, 2, mk(`NCPU_OP_ADD, 8 + 2*b, 0, 0), mk(`NCPU_OP_ADD, 9 + 2*b, 0, 0),
              0, 0, 0, 0, 0);
      check_eq("full_ready", 32'(fe_ready), 32'd0);
      step(1, 2, mk(`NCPU_OP_SUB, 20, 0, 0), mk(`NCPU_OP_SUB, 21, 0, 0), 0, 0, 0, 0, 0);
      check_eq("full_hold", 32'(fe_ready), 32'd0);
      step(0, 1, 0, 0, 0, 0, 1, 0, 0);
      check_eq("unfull_ready", 32'(fe_ready), 32'd1);
      check_eq("wrap_head", iss_insn[31:0], mk(`NCPU_OP_ADD, 10, 0, 0));
      repeat (3) step(0, 1, 0, 0, 0, 0, 1, 0, 0);
      check_eq("fill_empty", 32'(iss_cnt), 32'd0);

      // Serialising head and exception entry.
      step(1, 2, mk(`NCPU_OP_SYSCALL, 0, 0, 0), mk(`NCPU_OP_ADD, 5, 1, 2), 0, 0, 0, 0, 0);
      check_eq("ser_cnt", 32'(iss_cnt), 32'd1);
      check_eq("ser_flag", 32'(iss_serial[0]), 32'd1);
      check_eq("ser_wb", 32'(iss_wb_regf[0]), 32'd0);
      step(0, 1, 0, 0, 0, 0, 1, 0, 0);
      step(0, 1, 0, 0, 0, 0, 1, 0, 0);
      step(1, 1, mk(`NCPU_OP_ADD, 6, 1, 2), 0, 3'b010, 0, 0, 0, 0);
      check_eq("exc_rs1", 32'(iss_rs1_re[0]), 32'd0);
      check_eq("exc_rs2", 32'(iss_rs2_re[0]), 32'd0);
      check_eq("exc_wb", 32'(iss_wb_regf[0]), 32'd0);
      step(0, 1, 0, 0, 0, 0, 1, 0, 0);

      // Flush and reset override concurrent traffic.
      step(1, 2, mk(`NCPU_OP_ADD, 1, 0, 0), mk(`NCPU_OP_ADD, 2, 0, 0), 0, 0, 0, 0, 0);
      step(1, 2, mk(`NCPU_OP_ADD, 3, 0, 0), mk(`NCPU_OP_ADD, 4, 0, 0), 0, 0, 1, 1, 0);
      check_eq("flush_cnt", 32'(iss_cnt), 32'd0);
      check_eq("flush_ready", 32'(fe_ready), 32'd1);
      step(1, 2, mk(`NCPU_OP_ADD, 1, 0, 0), mk(`NCPU_OP_ADD, 2, 0, 0), 0, 0, 0, 0, 0);
      step(1, 2, mk(`NCPU_OP_ADD, 3, 0, 0), mk(`NCPU_OP_ADD, 4, 0, 0), 0, 0, 1, 0, 1);
      check_eq("rst_mid_cnt", 32'(iss_cnt), 32'd0);
      check_eq("rst_mid_ready", 32'(fe_ready), 32'd1);

      for (int i = 0; i < 3000; i++) begin
         a0 = rand_insn();
         a1 = rand_insn();
         step($urandom_range(0, 3) != 0, $urandom_range(1, 2), a0, a1,
              ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'b000,
              ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'b000,
              $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0,
              $urandom_range(0, 199) == 0);
      end
      check_model();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
